// File: rtl/decode_stage_p.sv
// Decode stage: register file with write-through, operand forwarding,
// branch/jump resolution with redirect to fetch, a valid/flush output
// register and saturating branch statistics.
module decode_stage_p #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = 3,
  parameter int ZERO_R0  = 0,
  parameter int LINK_REG = 7,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] next_pc,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [REG_AW-1:0] dest_in,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] fwd_alu,
  input  logic [DATA_W-1:0] fwd_mem,
  input  logic [DATA_W-1:0] fwd_wb,
  input  logic [1:0]        fwd1_sel,
  input  logic [1:0]        fwd2_sel,
  input  logic [1:0]        imm_sel,
  input  logic              zext8,
  input  logic              op2_imm,
  input  logic              load_link,
  input  logic              branch,
  input  logic              jump,
  input  logic [1:0]        cond,
  input  logic              pc_rel,
  input  logic              off11,
  output logic [DATA_W-1:0] true_pc,
  output logic              taken,
  output logic [REG_AW-1:0] link_addr,
  output logic [DATA_W-1:0] op1_q,
  output logic [DATA_W-1:0] op2_q,
  output logic [REG_AW-1:0] dest_q,
  output logic              valid_q,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  br_taken_cnt
);

  localparam bit ZeroR0 = (ZERO_R0 != 0);

  logic [DATA_W-1:0] regFile [NUM_REGS];
  logic [DATA_W-1:0] rsVal, rtVal, opA, opB, op1, op2, immVal;
  logic [DATA_W-1:0] sext5, sext8, sext11, zextImm, tgtBase, tgtOff, target;
  logic              condTrue, isZero, isNeg, loadCycle;
  logic              unusedInstr;

  // Upper opcode bits are decoded upstream; only [10:0] carry immediates here.
  assign unusedInstr = ^instr[15:11];
  assign link_addr   = REG_AW'(LINK_REG);

  // Register file write port; R0 stays zero when hardwired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
    end else if (wr_en && !(ZeroR0 && wr_addr == '0)) begin
      regFile[wr_addr] <= wr_data;
    end
  end

  // Read ports with same-cycle write-through; hardwired R0 overrides both.
  always_comb begin
    rsVal = regFile[rs_addr];
    rtVal = regFile[rt_addr];
    if (wr_en && wr_addr == rs_addr) rsVal = wr_data;
    if (wr_en && wr_addr == rt_addr) rtVal = wr_data;
    if (ZeroR0 && rs_addr == '0) rsVal = '0;
    if (ZeroR0 && rt_addr == '0) rtVal = '0;
  end

  // Forwarding muxes for both operands.
  always_comb begin
    opA = rsVal;
    opB = rtVal;
    case (fwd1_sel)
      2'b00:   opA = fwd_alu;
      2'b01:   opA = fwd_mem;
      2'b10:   opA = fwd_wb;
      default: opA = rsVal;
    endcase
    case (fwd2_sel)
      2'b00:   opB = fwd_alu;
      2'b01:   opB = fwd_mem;
      2'b10:   opB = fwd_wb;
      default: opB = rtVal;
    endcase
  end

  assign sext5   = {{(DATA_W-5){instr[4]}}, instr[4:0]};
  assign sext8   = {{(DATA_W-8){instr[7]}}, instr[7:0]};
  assign sext11  = {{(DATA_W-11){instr[10]}}, instr[10:0]};
  assign zextImm = zext8 ? {{(DATA_W-8){1'b0}}, instr[7:0]}
                         : {{(DATA_W-4){1'b0}}, instr[3:0]};

  // Immediate select and final operand selection.
  always_comb begin
    immVal = sext5;
    case (imm_sel)
      2'b00:   immVal = sext5;
      2'b01:   immVal = sext8;
      2'b10:   immVal = sext11;
      default: immVal = zextImm;
    endcase
    op1 = load_link ? next_pc : opA;
    op2 = op2_imm ? immVal : opB;
  end

  // Branch condition on operand A (signed) and target arithmetic.
  always_comb begin
    isZero   = (opA == '0);
    isNeg    = opA[DATA_W-1];
    condTrue = isZero;
    case (cond)
      2'b00:   condTrue = isZero;
      2'b01:   condTrue = ~isZero;
      2'b10:   condTrue = isNeg;
      default: condTrue = isNeg | isZero;
    endcase
    tgtBase = pc_rel ? next_pc : opA;
    tgtOff  = off11 ? sext11 : sext8;
    target  = tgtBase + tgtOff;
  end

  // A stalled instruction must not redirect fetch until it is released.
  assign taken     = valid_in & ~stall & ((branch & condTrue) | jump);
  assign true_pc   = taken ? target : next_pc;
  assign loadCycle = ~flush & ~stall;

  // Output pipeline register: flush squashes valid only, stall holds all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q   <= '0;
      op2_q   <= '0;
      dest_q  <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      op1_q   <= op1;
      op2_q   <= op2;
      dest_q  <= dest_in;
      valid_q <= valid_in;
    end
  end

  // Saturating branch statistics, counted only when the branch is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt       <= '0;
      br_taken_cnt <= '0;
    end else if (loadCycle && valid_in && branch) begin
      if (br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
      if (taken && br_taken_cnt != '1) br_taken_cnt <= br_taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: two instances share stimulus, one with a
// normal R0 and 8-bit counters, one with hardwired R0 and 2-bit counters.
module tb_decode_stage_p;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall, flush, valid_in, wr_en, zext8, op2_imm, load_link;
  logic        branch, jump, pc_rel, off11;
  logic [15:0] instr, next_pc, wr_data, fwd_alu, fwd_mem, fwd_wb;
  logic [2:0]  rs_addr, rt_addr, dest_in, wr_addr;
  logic [1:0]  fwd1_sel, fwd2_sel, imm_sel, cond;

  logic [15:0] truePc [2];
  logic        takenO [2];
  logic [2:0]  linkO  [2];
  logic [15:0] op1Q   [2];
  logic [15:0] op2Q   [2];
  logic [2:0]  destQ  [2];
  logic        validQ [2];
  logic [7:0]  brA, brTkA;
  logic [1:0]  brB, brTkB;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] mRegs [2][8];
  logic [15:0] mOp1 [2];
  logic [15:0] mOp2 [2];
  logic [2:0]  mDest;
  logic        mValid, mKnown;
  int          mBr [2];
  int          mTk [2];
  int          satMax [2] = '{255, 3};

  always #5 clk = ~clk;

  decode_stage_p #(.ZERO_R0(0), .CNT_W(8)) dutA (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .instr(instr), .next_pc(next_pc), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .dest_in(dest_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fwd_alu(fwd_alu), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .imm_sel(imm_sel), .zext8(zext8),
    .op2_imm(op2_imm), .load_link(load_link), .branch(branch), .jump(jump),
    .cond(cond), .pc_rel(pc_rel), .off11(off11),
    .true_pc(truePc[0]), .taken(takenO[0]), .link_addr(linkO[0]),
    .op1_q(op1Q[0]), .op2_q(op2Q[0]), .dest_q(destQ[0]), .valid_q(validQ[0]),
    .br_cnt(brA), .br_taken_cnt(brTkA));

  decode_stage_p #(.ZERO_R0(1), .CNT_W(2)) dutB (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .instr(instr), .next_pc(next_pc), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .dest_in(dest_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fwd_alu(fwd_alu), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .imm_sel(imm_sel), .zext8(zext8),
    .op2_imm(op2_imm), .load_link(load_link), .branch(branch), .jump(jump),
    .cond(cond), .pc_rel(pc_rel), .off11(off11),
    .true_pc(truePc[1]), .taken(takenO[1]), .link_addr(linkO[1]),
    .op1_q(op1Q[1]), .op2_q(op2Q[1]), .dest_q(destQ[1]), .valid_q(validQ[1]),
    .br_cnt(brB), .br_taken_cnt(brTkB));

  function automatic int cntOf(int d, bit tk);
    if (d == 0) return tk ? int'(brTkA) : int'(brA);
    return tk ? int'(brTkB) : int'(brB);
  endfunction

  // ---------------- reference model ----------------
  function automatic int sext(int bits, int v);
    int m;
    m = v % (1 << bits);
    if (m >= (1 << (bits - 1))) m -= (1 << bits);
    return m;
  endfunction

  function automatic logic [15:0] rdReg(int d, logic [2:0] a);
    if (d == 1 && a == 0) return 16'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return mRegs[d][a];
  endfunction

  function automatic logic [15:0] opnd(int d, logic [1:0] sel, logic [2:0] a);
    if (sel == 0) return fwd_alu;
    if (sel == 1) return fwd_mem;
    if (sel == 2) return fwd_wb;
    return rdReg(d, a);
  endfunction

  function automatic logic [15:0] immOf();
    int v = int'(instr);
    if (imm_sel == 0) return 16'(sext(5, v));
    if (imm_sel == 1) return 16'(sext(8, v));
    if (imm_sel == 2) return 16'(sext(11, v));
    return zext8 ? 16'(v % 256) : 16'(v % 16);
  endfunction

  function automatic bit expTaken(int d);
    int sa = int'($signed(opnd(d, fwd1_sel, rs_addr)));
    bit c;
    case (cond)
      2'd0: c = (sa == 0);
      2'd1: c = (sa != 0);
      2'd2: c = (sa < 0);
      default: c = (sa <= 0);
    endcase
    return valid_in && !stall && ((branch && c) || jump);
  endfunction

  function automatic logic [15:0] expPc(int d);
    int base, off;
    if (!expTaken(d)) return next_pc;
    base = pc_rel ? int'(next_pc) : int'(opnd(d, fwd1_sel, rs_addr));
    off  = off11 ? sext(11, int'(instr)) : sext(8, int'(instr));
    return 16'(base + off);
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 8; r++) mRegs[d][r] = 16'h0;
      mOp1[d] = 16'h0; mOp2[d] = 16'h0; mBr[d] = 0; mTk[d] = 0;
    end
    mDest = 3'd0; mValid = 1'b0; mKnown = 1'b1;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    logic [15:0] n1 [2];
    logic [15:0] n2 [2];
    bit tk [2];
    for (int d = 0; d < 2; d++) begin
      n1[d] = load_link ? next_pc : opnd(d, fwd1_sel, rs_addr);
      n2[d] = op2_imm ? immOf() : opnd(d, fwd2_sel, rt_addr);
      tk[d] = expTaken(d);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!flush && !stall && valid_in && branch) begin
        if (mBr[d] < satMax[d]) mBr[d]++;
        if (tk[d] && mTk[d] < satMax[d]) mTk[d]++;
      end
      if (wr_en && !(d == 1 && wr_addr == 0)) mRegs[d][wr_addr] = wr_data;
      if (!flush && !stall) begin
        mOp1[d] = n1[d]; mOp2[d] = n2[d];
      end
    end
    if (flush) begin
      mValid = 1'b0; mKnown = 1'b0;
    end else if (!stall) begin
      mDest = dest_in; mValid = valid_in; mKnown = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; valid_in = 0; wr_en = 0; zext8 = 0; op2_imm = 0;
    load_link = 0; branch = 0; jump = 0; pc_rel = 0; off11 = 0;
    instr = 16'h0; next_pc = 16'h0; wr_data = 16'h0; fwd_alu = 16'h0;
    fwd_mem = 16'h0; fwd_wb = 16'h0; rs_addr = 0; rt_addr = 0; dest_in = 0;
    wr_addr = 0; fwd1_sel = 0; fwd2_sel = 0; imm_sel = 0; cond = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    rst = 1'b1;
    modelReset();
    #12;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (op1Q[d] !== 16'h0 || op2Q[d] !== 16'h0 || destQ[d] !== 3'd0 ||
          validQ[d] !== 1'b0 || cntOf(d, 0) != 0 || cntOf(d, 1) != 0) begin
        errors++;
        $display("FAIL reset_state dut%0d got op1=%h op2=%h dest=%0d v=%b br=%0d tk=%0d want all 0",
                 d, op1Q[d], op2Q[d], destQ[d], validQ[d], cntOf(d, 0), cntOf(d, 1));
      end
      checks++;
      if (linkO[d] !== 3'd7) begin
        errors++;
        $display("FAIL link_addr dut%0d got %0d want 7", d, linkO[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    idle();
    for (int i = 0; i < 5; i++) begin
      valid_in = 1; branch = 1; cond = 2'(i); fwd1_sel = 0;
      fwd_alu = 16'(i * 16'h1234); next_pc = 16'(16'h0100 + i);
      instr = 16'h0003; wr_en = 1;
      wr_addr = (i % 2 == 0) ? 3'd3 : 3'd5;
      wr_data = (i % 2 == 0) ? 16'h1111 : 16'h2222;
      tick();
    end
    checks++;
    if (brA !== 8'd5 || validQ[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset br_cnt=%0d valid_q=%b want 5 1", brA, validQ[0]);
    end
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (validQ[d] !== 1'b0 || cntOf(d, 0) != 0 || cntOf(d, 1) != 0 ||
          op1Q[d] !== 16'h0 || op2Q[d] !== 16'h0 || destQ[d] !== 3'd0) begin
        errors++;
        $display("FAIL async_reset dut%0d got v=%b br=%0d tk=%0d op1=%h want 0",
                 d, validQ[d], cntOf(d, 0), cntOf(d, 1), op1Q[d]);
      end
    end
    #1 rst = 1'b0;
    modelReset();
    idle();
    rs_addr = 3; rt_addr = 5; fwd1_sel = 3; fwd2_sel = 3; op2_imm = 0;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (op1Q[d] !== 16'h0 || op2Q[d] !== 16'h0) begin
        errors++;
        $display("FAIL regfile_cleared dut%0d got %h %h want 0 0", d, op1Q[d], op2Q[d]);
      end
    end
  endtask

  task automatic test_write_through();
    idle();
    valid_in = 1; wr_en = 1; wr_addr = 3; wr_data = 16'hBEEF; rs_addr = 3; fwd1_sel = 3;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (op1Q[d] !== 16'hBEEF) begin
        errors++;
        $display("FAIL write_through dut%0d got %h want beef", d, op1Q[d]);
      end
    end
    wr_addr = 0; wr_data = 16'h1234; rs_addr = 0;
    tick();
    checks++;
    if (op1Q[0] !== 16'h1234 || op1Q[1] !== 16'h0000) begin
      errors++;
      $display("FAIL r0_write_through got %h %h want 1234 0000", op1Q[0], op1Q[1]);
    end
    wr_en = 0;
    tick();
    checks++;
    if (op1Q[0] !== 16'h1234 || op1Q[1] !== 16'h0000) begin
      errors++;
      $display("FAIL r0_stored got %h %h want 1234 0000", op1Q[0], op1Q[1]);
    end
  endtask

  task automatic test_bnez();
    idle();
    valid_in = 1; branch = 1; cond = 2'b01; pc_rel = 1; off11 = 0;
    instr = 16'h00FE; next_pc = 16'h0010; fwd1_sel = 0; fwd_alu = 16'h0001;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (takenO[d] !== 1'b1 || truePc[d] !== 16'h000E) begin
        errors++;
        $display("FAIL bnez_taken dut%0d got %b %h want 1 000e", d, takenO[d], truePc[d]);
      end
    end
    fwd_alu = 16'h0000;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (takenO[d] !== 1'b0 || truePc[d] !== 16'h0010) begin
        errors++;
        $display("FAIL bnez_not_taken dut%0d got %b %h want 0 0010", d, takenO[d], truePc[d]);
      end
    end
    tick();
  endtask

  task automatic test_forwarding();
    idle();
    valid_in = 1; fwd1_sel = 0; fwd2_sel = 2; fwd_alu = 16'h0007; fwd_wb = 16'h0009;
    fwd_mem = 16'h0BAD; dest_in = 4;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (op1Q[d] !== 16'h0007 || op2Q[d] !== 16'h0009 || destQ[d] !== 3'd4) begin
        errors++;
        $display("FAIL forward_both dut%0d got %h %h %0d want 0007 0009 4",
                 d, op1Q[d], op2Q[d], destQ[d]);
      end
    end
    fwd_alu = 16'h8000; branch = 1; cond = 2'b11; pc_rel = 1; next_pc = 16'h0200; instr = 16'h0004;
    #1;
    checks++;
    if (takenO[0] !== 1'b1 || truePc[0] !== 16'h0204) begin
      errors++;
      $display("FAIL lez_negative got %b %h want 1 0204", takenO[0], truePc[0]);
    end
    tick();
  endtask

  task automatic test_stall_flush();
    idle();
    valid_in = 1; fwd1_sel = 0; fwd_alu = 16'h0055; dest_in = 2;
    tick();
    branch = 1; cond = 2'b00; fwd_alu = 16'h0000; dest_in = 6; stall = 1;
    pc_rel = 1; next_pc = 16'h0300; instr = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (takenO[0] !== 1'b0) begin
        errors++;
        $display("FAIL stall_no_redirect cycle%0d got %b want 0", i, takenO[0]);
      end
      tick();
      checks++;
      if (op1Q[0] !== 16'h0055 || destQ[0] !== 3'd2 || validQ[0] !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cycle%0d got %h %0d %b want 0055 2 1",
                 i, op1Q[0], destQ[0], validQ[0]);
      end
    end
    stall = 0;
    #1;
    checks++;
    if (takenO[0] !== 1'b1 || truePc[0] !== 16'h0310) begin
      errors++;
      $display("FAIL release_redirect got %b %h want 1 0310", takenO[0], truePc[0]);
    end
    tick();
    checks++;
    if (op1Q[0] !== 16'h0000 || destQ[0] !== 3'd6) begin
      errors++;
      $display("FAIL release_load got %h %0d want 0000 6", op1Q[0], destQ[0]);
    end
    stall = 1; flush = 1;
    tick();
    checks++;
    if (validQ[0] !== 1'b0 || validQ[1] !== 1'b0) begin
      errors++;
      $display("FAIL stall_flush got %b %b want 0 0", validQ[0], validQ[1]);
    end
    idle();
  endtask

  task automatic test_saturation();
    idle();
    valid_in = 1; branch = 1; jump = 0; cond = 2'b00; fwd1_sel = 0; fwd_alu = 16'h0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (int'(brB) != mBr[1] || int'(brTkB) != mTk[1] || int'(brA) != mBr[0]) begin
        errors++;
        $display("FAIL sat_step%0d got %0d %0d %0d want %0d %0d %0d",
                 i, brB, brTkB, brA, mBr[1], mTk[1], mBr[0]);
      end
    end
    checks++;
    if (brB !== 2'd3 || brTkB !== 2'd3) begin
      errors++;
      $display("FAIL saturated got %0d %0d want 3 3", brB, brTkB);
    end
    branch = 0; jump = 1;
    tick();
    checks++;
    if (int'(brA) != mBr[0] || int'(brTkA) != mTk[0]) begin
      errors++;
      $display("FAIL jump_not_counted got %0d %0d want %0d %0d", brA, brTkA, mBr[0], mTk[0]);
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(0, 3) == 0); flush = ($urandom_range(0, 7) == 0);
      valid_in = ($urandom_range(0, 3) != 0); wr_en = $urandom_range(0, 1);
      zext8 = $urandom_range(0, 1); op2_imm = $urandom_range(0, 1);
      load_link = ($urandom_range(0, 3) == 0); branch = $urandom_range(0, 1);
      jump = ($urandom_range(0, 5) == 0); pc_rel = $urandom_range(0, 1);
      off11 = $urandom_range(0, 1); instr = 16'($urandom); next_pc = 16'($urandom);
      wr_data = 16'($urandom); fwd_mem = 16'($urandom); fwd_wb = 16'($urandom);
      fwd_alu = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      rs_addr = 3'($urandom); rt_addr = 3'($urandom); dest_in = 3'($urandom);
      wr_addr = ($urandom_range(0, 1) == 0) ? rs_addr : 3'($urandom);
      fwd1_sel = 2'($urandom); fwd2_sel = 2'($urandom);
      imm_sel = 2'($urandom); cond = 2'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (takenO[d] !== expTaken(d) || truePc[d] !== expPc(d)) begin
          errors++;
          $display("FAIL rand_redirect n%0d dut%0d got %b %h want %b %h",
                   n, d, takenO[d], truePc[d], expTaken(d), expPc(d));
        end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (validQ[d] !== mValid || cntOf(d, 0) != mBr[d] || cntOf(d, 1) != mTk[d] ||
            (mKnown && (op1Q[d] !== mOp1[d] || op2Q[d] !== mOp2[d] || destQ[d] !== mDest))) begin
          errors++;
          $display("FAIL rand_regs n%0d dut%0d got v=%b op1=%h op2=%h dst=%0d br=%0d tk=%0d want v=%b op1=%h op2=%h dst=%0d br=%0d tk=%0d",
                   n, d, validQ[d], op1Q[d], op2Q[d], destQ[d], cntOf(d, 0), cntOf(d, 1),
                   mValid, mOp1[d], mOp2[d], mDest, mBr[d], mTk[d]);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_write_through();
    test_bnez();
    test_forwarding();
    test_stall_flush();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
